alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational datapath ALU. It adds logic, shift and multi-cycle multiply modes, a registered flag set (C/Z/N/V) and a start/busy/done handshake.
- Sits between the register file and the bus in the controller's execute stage.
- The controller issues one operation, waits for done, then samples out/out_hi/flags.

Parameters:
- N, 8, operand/result width; legal range 4..32.
- CW, 6, multiply iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  request; operands and mode captured on the same edge when not busy.
- mode  in  4  operation code, `ALU_* macros in the shared parameters file.
- cin  in  1  carry-in for ADD.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- out  out  N  registered result; low half for MUL.
- out_hi  out  N  high half of MUL product; 0 for every other op.
- flags  out  4  registered {C,Z,N,V}.
- busy  out  1  high while a MUL iterates.
- done  out  1  one-cycle pulse when out/out_hi/flags update.

Behaviour:
- Reset values: out=0, out_hi=0, flags=0, busy=0, done=0, FSM=IDLE, counter=0. Reset has priority over everything; a MUL in progress is aborted with no done pulse.
- FSM has two states, IDLE and MUL.
- IDLE with start=1 and a single-cycle op (edge t):
  - Result and flags register at edge t.
  - done=1 during cycle t+1, busy stays 0, FSM stays IDLE.
- IDLE with start=1 and mode=MUL:
  - Latch in_a/in_b, clear the accumulator, counter=N-1, busy=1, go to MUL.
- MUL state:
  - One shift-add step per cycle: if multiplier LSB is set, add the multiplicand to the upper accumulator; then shift right 1. The product is unsigned, 2N bits.
  - When counter=0: write out/out_hi, update flags, busy=0, done=1 next cycle, return to IDLE.
  - busy is high for exactly N cycles; done follows in cycle t+N+1.
- start while busy=1 is ignored: no capture, no queueing.
- start is accepted again in the done cycle, so back-to-back ops are allowed.
- done is never high on two consecutive cycles unless back-to-back starts are issued.
- ADD: {C,out} = in_a + in_b + cin, computed in N+1 bits; wraps mod 2^N. V = signed overflow.
- SUB: out = in_a - in_b mod 2^N.
  - C = borrow (in_a < in_b unsigned).
  - V = signed overflow; cin is ignored.
- AND/OR/XOR: bitwise. C=0, V=0.
- SHL: out = in_a << 1, C = in_a[N-1], V=0.
- SHR: logical right shift by 1, C = in_a[0], V=0.
- MUL flags:
  - C = (out_hi != 0); V=0.
  - Z = full 2N-bit product is zero.
  - N = out_hi[N-1].
- All other ops: Z = (out == 0), N = out[N-1].
- Unknown mode code: done still pulses; out, out_hi and flags hold their previous values.
- Outputs change only on a completion edge or on reset. No combinational path from inputs to outputs.

Decomposition:
- Shared parameters file holds the `ALU_* codes:
  - ADD and SUB keep their existing values.
  - New codes for AND, OR, XOR, SHL, SHR, MUL.
  - Flag bit-index macros FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0.
- One sub-module is natural: alu_mul_seq, the N-cycle shift-add multiplier with its own counter and its own start/done.
- The top level holds the single-cycle combinational ops, the flag logic and the IDLE/MUL FSM.

Test Plan (N=8):
- ADD in_a=0xFF, in_b=0x01, cin=0 -> out=0x00, flags C=1 Z=1 N=0 V=0; done in cycle t+1; busy never high.
- SUB in_a=0x80, in_b=0x01 -> out=0x7F, C=0, Z=0, N=0, V=1. SUB 0x01-0x02 -> out=0xFF, C=1, N=1.
- MUL 0xFF*0xFF -> busy high 8 cycles, done in cycle t+9; out=0x01, out_hi=0xFE, C=1, Z=0, N=1. MUL 0x0F*0x11 -> out=0xFF, out_hi=0x00, C=0.
- MUL 0x03*0x05 with start pulsed mid-busy using ADD 0x01+0x01 -> second start ignored; single done; out=0x0F, out_hi=0x00.
- reset asserted on 4th busy cycle of MUL 0xAA*0x55 -> next cycle: busy=0, out=0, out_hi=0, flags=0; no done pulse. A following ADD 0x02+0x03 gives out=0x05 at t+1.
- SHL in_a=0x81 -> out=0x02, C=1. SHR in_a=0x01 -> out=0x00, C=1, Z=1. XOR 0xF0^0xF0 -> out=0x00, Z=1, C=0. Back-to-back starts on consecutive done cycles each yield a done pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared operation codes, flag bit positions and FSM state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_MUL = 4'd7;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [0:0] {StIdle, StMul} alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Controller-side request/result bundle of the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [3:0]   mode;
  logic         cin;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] out;
  logic [N-1:0] out_hi;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  modport master (
    output start, mode, cin, in_a, in_b,
    input  out, out_hi, flags, busy, done
  );

  modport slave (
    input  start, mode, cin, in_a, in_b,
    output out, out_hi, flags, busy, done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// N-cycle unsigned shift-add multiplier; done/product are valid in the cycle whose
// closing edge performs the final step, so the caller can register them on that edge.
module alu_mul_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic [N:0]     partial;
  logic [2*N-1:0] step;

  always_comb begin
    // Upper half accumulates the multiplicand, lower half holds the remaining multiplier bits.
    partial = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    step    = {partial, acc_q[N-1:1]};
    done    = run_q && (cnt_q == '0);
    product = step;

    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      mcand_d = a;
      acc_d   = {{N{1'b0}}, b};
      cnt_d   = CW'(N - 1);
      run_d   = 1'b1;
    end else if (run_q) begin
      acc_d = step;
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith/shift ops, multi-cycle multiply, C/Z/N/V flags
// and a start/busy/done handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 6
) (
  input logic     clk,
  input logic     reset,
  alu_seq_if.slave bus
);

  alu_state_e     state_q, state_d;
  logic [N-1:0]   out_q, out_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [3:0]     flags_q, flags_d;
  logic           done_q, done_d;

  logic [N:0]     add_sum;
  logic [N:0]     sub_dif;
  logic [N-1:0]   op_res;
  logic           op_c, op_v, op_ok;
  logic           mul_start, mul_done;
  logic [2*N-1:0] mul_prod;

  alu_mul_seq #(
    .N  (N),
    .CW (CW)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    add_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{N{1'b0}}, bus.cin};
    sub_dif = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    op_res  = '0;
    op_c    = 1'b0;
    op_v    = 1'b0;
    op_ok   = 1'b1;
    case (bus.mode)
      ALU_ADD: begin
        op_res = add_sum[N-1:0];
        op_c   = add_sum[N];
        op_v   = (bus.in_a[N-1] == bus.in_b[N-1]) && (add_sum[N-1] != bus.in_a[N-1]);
      end
      ALU_SUB: begin
        op_res = sub_dif[N-1:0];
        op_c   = sub_dif[N];
        op_v   = (bus.in_a[N-1] != bus.in_b[N-1]) && (sub_dif[N-1] != bus.in_a[N-1]);
      end
      ALU_AND: op_res = bus.in_a & bus.in_b;
      ALU_OR:  op_res = bus.in_a | bus.in_b;
      ALU_XOR: op_res = bus.in_a ^ bus.in_b;
      ALU_SHL: begin
        op_res = {bus.in_a[N-2:0], 1'b0};
        op_c   = bus.in_a[N-1];
      end
      ALU_SHR: begin
        op_res = {1'b0, bus.in_a[N-1:1]};
        op_c   = bus.in_a[0];
      end
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    hi_d      = hi_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.mode == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end else begin
            // Unknown codes still complete, but leave the result registers untouched.
            done_d = 1'b1;
            if (op_ok) begin
              out_d           = op_res;
              hi_d            = '0;
              flags_d[FLAG_C] = op_c;
              flags_d[FLAG_Z] = (op_res == '0);
              flags_d[FLAG_N] = op_res[N-1];
              flags_d[FLAG_V] = op_v;
            end
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d         = StIdle;
          done_d          = 1'b1;
          out_d           = mul_prod[N-1:0];
          hi_d            = mul_prod[2*N-1:N];
          flags_d[FLAG_C] = (mul_prod[2*N-1:N] != '0);
          flags_d[FLAG_Z] = (mul_prod == '0);
          flags_d[FLAG_N] = mul_prod[2*N-1];
          flags_d[FLAG_V] = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.out_hi = hi_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == StMul);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 6;
  localparam longint      M  = longint'(1) << N;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int           m_left;
  logic [N-1:0] m_out, m_hi, p_out, p_hi;
  logic [3:0]   m_flags, p_flags;
  logic         m_done;

  function automatic void model_op(input logic [3:0] m, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic ci, output bit ok,
                                   output logic [N-1:0] r, output logic [3:0] f);
    longint ua, ub, sa, sb, s, sv;
    bit c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= M / 2) ? ua - M : ua;
    sb = (ub >= M / 2) ? ub - M : ub;
    c  = 1'b0;
    v  = 1'b0;
    ok = 1'b1;
    s  = 0;
    case (m)
      ALU_ADD: begin
        s  = ua + ub + longint'(ci);
        c  = (s >= M);
        sv = sa + sb + longint'(ci);
        v  = (sv > M / 2 - 1) || (sv < -(M / 2));
      end
      ALU_SUB: begin
        s  = ua - ub + M;
        c  = (ua < ub);
        sv = sa - sb;
        v  = (sv > M / 2 - 1) || (sv < -(M / 2));
      end
      ALU_AND: s = longint'(a & b);
      ALU_OR:  s = longint'(a | b);
      ALU_XOR: s = longint'(a ^ b);
      ALU_SHL: begin
        s = ua * 2;
        c = (ua >= M / 2);
      end
      ALU_SHR: begin
        s = ua / 2;
        c = (ua % 2) == 1;
      end
      default: ok = 1'b0;
    endcase
    r = N'(s % M);
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = (s % M) == 0;
    f[FLAG_N] = (s % M) >= M / 2;
    f[FLAG_V] = v;
  endfunction

  task automatic model_step();
    bit           ok;
    logic [N-1:0] r;
    logic [3:0]   f;
    longint       p;
    if (reset) begin
      m_left = 0; m_out = '0; m_hi = '0; m_flags = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out = p_out; m_hi = p_hi; m_flags = p_flags; m_done = 1'b1;
        end
      end else if (bus.start) begin
        if (bus.mode == ALU_MUL) begin
          p       = longint'(bus.in_a) * longint'(bus.in_b);
          p_out   = N'(p % M);
          p_hi    = N'(p / M);
          p_flags = '0;
          p_flags[FLAG_C] = (p / M) != 0;
          p_flags[FLAG_Z] = (p == 0);
          p_flags[FLAG_N] = (p / M) >= M / 2;
          m_left  = N;
        end else begin
          m_done = 1'b1;
          model_op(bus.mode, bus.in_a, bus.in_b, bus.cin, ok, r, f);
          if (ok) begin
            m_out = r; m_hi = '0; m_flags = f;
          end
        end
      end
    end
  endtask

  // Single compare process: model advances on each edge, DUT is checked 1 ns later.
  initial begin
    m_left = 0; m_out = '0; m_hi = '0; m_flags = '0; m_done = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("cyc_out", longint'(bus.out), longint'(m_out));
      chk("cyc_out_hi", longint'(bus.out_hi), longint'(m_hi));
      chk("cyc_flags", longint'(bus.flags), longint'(m_flags));
      chk("cyc_busy", longint'(bus.busy), longint'(m_left > 0));
      chk("cyc_done", longint'(bus.done), longint'(m_done));
    end
  end

  task automatic issue(input logic [3:0] m, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci);
    bus.start = 1'b1; bus.mode = m; bus.in_a = a; bus.in_b = b; bus.cin = ci;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string name, input logic [3:0] m, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic ci, input logic [N-1:0] e_out,
                        input logic [N-1:0] e_hi, input logic [3:0] e_flags, input int e_lat);
    int lat;
    issue(m, a, b, ci);
    wait_done(lat);
    chk({name, "_lat"}, longint'(lat), longint'(e_lat));
    chk({name, "_out"}, longint'(bus.out), longint'(e_out));
    chk({name, "_hi"}, longint'(bus.out_hi), longint'(e_hi));
    chk({name, "_flags"}, longint'(bus.flags), longint'(e_flags));
    @(negedge clk);
  endtask

  initial begin
    int lat, ndone, r;
    total = 0; bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = '0; bus.cin = 1'b0; bus.in_a = '0; bus.in_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_out", longint'(bus.out), 0);
    chk("rst_flags", longint'(bus.flags), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);

    run_op("add_ff_01", ALU_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b1100, 1);
    run_op("sub_80_01", ALU_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 4'b0001, 1);
    run_op("sub_01_02", ALU_SUB, 8'h01, 8'h02, 1'b1, 8'hFF, 8'h00, 4'b1010, 1);
    run_op("mul_ff_ff", ALU_MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 4'b1010, 9);
    run_op("mul_0f_11", ALU_MUL, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 4'b0000, 9);

    // Start pulsed while multiplying must be dropped.
    issue(ALU_MUL, 8'h03, 8'h05, 1'b0);
    @(negedge clk);
    @(negedge clk);
    issue(ALU_ADD, 8'h01, 8'h01, 1'b0);
    wait_done(lat);
    chk("midbusy_out", longint'(bus.out), 'h0F);
    chk("midbusy_hi", longint'(bus.out_hi), 'h00);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midbusy_extra_done", longint'(ndone), 0);

    // Reset during the 4th busy cycle aborts the multiply.
    issue(ALU_MUL, 8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_out", longint'(bus.out), 0);
    chk("abort_hi", longint'(bus.out_hi), 0);
    chk("abort_flags", longint'(bus.flags), 0);
    chk("abort_done", longint'(bus.done), 0);
    run_op("add_02_03", ALU_ADD, 8'h02, 8'h03, 1'b0, 8'h05, 8'h00, 4'b0000, 1);

    run_op("shl_81", ALU_SHL, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 4'b1000, 1);
    run_op("unknown", 4'hF, 8'h33, 8'h44, 1'b1, 8'h02, 8'h00, 4'b1000, 1);
    run_op("shr_01", ALU_SHR, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 4'b1100, 1);
    run_op("xor_f0", ALU_XOR, 8'hF0, 8'hF0, 1'b0, 8'h00, 8'h00, 4'b0100, 1);

    // Back-to-back single-cycle starts: one done per start.
    ndone = 0;
    bus.start = 1'b1; bus.mode = ALU_ADD; bus.in_a = 8'h01; bus.in_b = 8'h02;
    @(negedge clk);
    if (bus.done) ndone++;
    bus.mode = ALU_SUB; bus.in_a = 8'h05; bus.in_b = 8'h03;
    @(negedge clk);
    if (bus.done) ndone++;
    bus.mode = ALU_AND; bus.in_a = 8'h3C; bus.in_b = 8'h0F;
    @(negedge clk);
    if (bus.done) ndone++;
    bus.start = 1'b0;
    chk("b2b_dones", longint'(ndone), 3);
    chk("b2b_out", longint'(bus.out), 'h0C);
    @(negedge clk);

    // Randomized traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      bus.mode  = (r <= 7) ? 4'(r) : ((r == 8) ? 4'd12 : ALU_MUL);
      bus.in_a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      bus.in_b  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      bus.cin   = 1'($urandom);
      @(negedge clk);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
